// File: rtl/serial_full_adder_seq_if.sv
// ---------------------------------------------------------------------------
// serial_full_adder_seq_if
//
// Groups the operand/result bus and the start/done handshake of the bit-serial
// adder so the requester and the adder connect through a single port.
//
// Handshake: the master raises start with A, B and carry_in stable; the
// request is taken on the first rising edge where ready=1 (start is ignored
// while ready=0). Y and carry_out are valid in the single cycle where done=1
// and keep that value until the next accepted start. en=0 freezes an
// operation that is in progress without consuming a bit.
//
// Signals
//   start     master->slave  request, sampled only while ready=1
//   en        master->slave  bit-step enable
//   A, B      master->slave  operands, captured on the accepted start edge
//   carry_in  master->slave  initial carry, captured with A/B
//   ready     slave->master  high in IDLE and DONE
//   busy      slave->master  high in RUN
//   Y         slave->master  sum, modulo 2^WIDTH
//   carry_out slave->master  bit WIDTH of the true sum
//   done      slave->master  one-cycle result-valid pulse
// ---------------------------------------------------------------------------
interface serial_full_adder_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             carry_in;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] Y;
  logic             carry_out;
  logic             done;

  modport master (
    output start, en, A, B, carry_in,
    input  ready, busy, Y, carry_out, done
  );

  modport slave (
    input  start, en, A, B, carry_in,
    output ready, busy, Y, carry_out, done
  );
endinterface

// File: rtl/serial_full_adder_seq.sv
// ---------------------------------------------------------------------------
// serial_full_adder_seq
//
// Bit-serial ripple adder: computes A + B + carry_in over WIDTH enabled clock
// cycles, one full-adder bit per cycle, LSB first. A single full-adder slice
// works on the low bits of two right-shifting operand registers; the carry is
// held in a register between steps and the sum bits shift into Y from the MSB
// end, so after WIDTH steps Y holds the complete sum.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any operation
//   bus        slave side of serial_full_adder_seq_if (handshake + operands)
//   state_dbg  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Parameter
//   WIDTH      operand/sum width, legal range 2..32
//
// Timing with en held high: edge E0 accepts start, edges E1..EWIDTH consume
// bits 0..WIDTH-1, done is high in the cycle after EWIDTH. Every en=0 cycle
// in RUN adds one cycle. A start accepted in DONE begins the next operation
// with no idle cycle. All outputs come straight from flops.
// ---------------------------------------------------------------------------
module serial_full_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_full_adder_seq_if.slave bus,
  output logic [1:0]             state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Datapath registers
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;

  // Output registers
  logic [WIDTH-1:0] y_q;
  logic             carry_out_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  // Control decodes
  logic accept;
  logic step;
  logic last_step;

  // Full-adder slice on the current LSBs
  logic sum_bit;
  logic carry_next;

  assign sum_bit    = sa_q[0] ^ sb_q[0] ^ c_q;
  assign carry_next = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));

  // -------------------------------------------------------------------------
  // FSM: next state and control decodes
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // DONE never lingers: it either starts the next job or drops to IDLE.
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // start is deliberately not looked at here.
        if (bus.en) begin
          step = 1'b1;
          if (cnt_q == LAST_BIT) begin
            last_step = 1'b1;
            state_d   = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe and carry no combinational path from inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_d != RUN);
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q        <= '0;
      sb_q        <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      y_q         <= '0;
      carry_out_q <= 1'b0;
    end else if (accept) begin
      // Y is left alone on purpose: it keeps the previous result until the
      // new sum bits overwrite it.
      sa_q        <= bus.A;
      sb_q        <= bus.B;
      c_q         <= bus.carry_in;
      cnt_q       <= '0;
      carry_out_q <= 1'b0;
    end else if (step) begin
      sa_q  <= sa_q >> 1;
      sb_q  <= sb_q >> 1;
      c_q   <= carry_next;
      y_q   <= {sum_bit, y_q[WIDTH-1:1]};
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        carry_out_q <= carry_next;
      end
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.Y         = y_q;
  assign bus.carry_out = carry_out_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_serial_full_adder_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_full_adder_seq
//
// Directed vector table for the bit-serial adder plus hand-written sequences
// for back-to-back start, stall, start-during-RUN, asynchronous reset in the
// middle of an operation and a random sweep with random stalls.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_full_adder_seq;

  localparam int W = 8;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_full_adder_seq_if #(.WIDTH(W)) bus ();
  logic [1:0] state_dbg;

  serial_full_adder_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int tests    = 0;
  int failed   = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver: called at a falling edge with the adder in IDLE or DONE. Returns
  // at the falling edge where done is seen (or after the cycle budget).
  // -------------------------------------------------------------------------
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int stall_at, input int stall_len,
                        input bit pulse, input logic [W:0] exp);
    int k;
    bit seen;
    logic [W:0] got_exp;
    check({name, "/ready_before"}, 32'(bus.ready), 32'd1);
    exp_q.push_back(exp);
    bus.start    = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.carry_in = cin;
    bus.en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 1;
    bus.start = 1'b0;
    check({name, "/busy"}, 32'(bus.busy), 32'd1);
    check({name, "/ready_run"}, 32'(bus.ready), 32'd0);
    seen = 1'b0;
    while (k < 60) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      bus.en = !(k >= stall_at && k < stall_at + stall_len);
      if (pulse && k == 2) begin
        // A start while busy must not reload the operands.
        bus.start    = 1'b1;
        bus.A        = ~a;
        bus.B        = ~b;
        bus.carry_in = ~cin;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    bus.en    = 1'b1;
    bus.start = 1'b0;
    check({name, "/latency"}, seen ? 32'(k) : 32'd0, 32'(W + 1 + stall_len));
    got_exp = exp_q.pop_front();
    if (seen) begin
      check({name, "/Y"}, 32'(bus.Y), 32'(got_exp[W-1:0]));
      check({name, "/carry_out"}, 32'(bus.carry_out), 32'(got_exp[W]));
      check({name, "/ready_done"}, 32'(bus.ready), 32'd1);
      check({name, "/busy_done"}, 32'(bus.busy), 32'd0);
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       cin;
    int         stall_at;
    int         stall_len;
    bit         pulse;
    bit         b2b;     // next vector starts in this vector's DONE cycle
    logic [W-1:0] exp_y;
    logic       exp_co;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;

    vecs[0] = '{"basic",   8'h5A, 8'h3C, 1'b0, 0, 0, 1'b0, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{"wrap",    8'hFF, 8'h01, 1'b0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{"cin",     8'hFF, 8'hFF, 1'b1, 0, 0, 1'b0, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{"b2b",     8'h01, 8'h02, 1'b0, 0, 0, 1'b0, 1'b0, 8'h03, 1'b0};
    vecs[4] = '{"stall",   8'h12, 8'h34, 1'b0, 4, 3, 1'b1, 1'b0, 8'h46, 1'b0};
    vecs[5] = '{"msb_co",  8'h80, 8'h80, 1'b0, 2, 1, 1'b0, 1'b0, 8'h00, 1'b1};

    // Reset state
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.en       = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.carry_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset/ready", 32'(bus.ready), 32'd1);
    check("reset/busy", 32'(bus.busy), 32'd0);
    check("reset/done", 32'(bus.done), 32'd0);
    check("reset/Y", 32'(bus.Y), 32'd0);
    check("reset/carry_out", 32'(bus.carry_out), 32'd0);
    check("reset/state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall_at,
             vecs[i].stall_len, vecs[i].pulse, {vecs[i].exp_co, vecs[i].exp_y});
      if (!vecs[i].b2b) begin
        @(negedge clk);
        check({vecs[i].name, "/done_one_cycle"}, 32'(bus.done), 32'd0);
        check({vecs[i].name, "/idle"}, 32'(state_dbg), 32'd0);
      end
    end

    // Asynchronous reset while bit 4 of 0xAA + 0x55 is pending
    bus.start    = 1'b1;
    bus.A        = 8'hAA;
    bus.B        = 8'h55;
    bus.carry_in = 1'b0;
    bus.en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort/busy_before", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort/Y", 32'(bus.Y), 32'd0);
    check("abort/carry_out", 32'(bus.carry_out), 32'd0);
    check("abort/done", 32'(bus.done), 32'd0);
    check("abort/ready", 32'(bus.ready), 32'd1);
    check("abort/busy", 32'(bus.busy), 32'd0);
    check("abort/state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_abort", 8'h0F, 8'h01, 1'b0, 0, 0, 1'b0, {1'b0, 8'h10});
    @(negedge clk);

    // Random sweep
    dc0 = done_cnt;
    for (int n = 0; n < 500; n++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rc = 1'($urandom_range(0, 1));
      run_op("rand", ra, rb, rc, $urandom_range(1, W), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("rand/done_count", 32'(done_cnt - dc0), 32'd500);
    check("rand/queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
